fpr_wb_scoreboard: RTL and testbench

- Controller for the 32 x 32-bit FP register file.
- Arbitrates its single write port between two writeback requesters: the multi-cycle FPU and the FLW load path.
- Keeps a per-register busy scoreboard that stalls FP instruction issue on RAW/WAW hazards.
- Sits between the decode/issue stage and the register file's wa/wd/we inputs.

---
 rtl/fp_wb_pkg.sv | 26 ++
 rtl/fp_wb_rr_arbiter.sv | 54 +++++
 rtl/fpr_wb_scoreboard.sv | 124 ++++++++++++
 tb/tb_fpr_wb_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_wb_pkg
// Description : Shared sizes, requester identifiers and the writeback record
//               used by the FP register-file writeback controller.
// Contents    : NREG/AW/DW sizes, req_id_e (REQ_FPU/REQ_LD), wb_rec_t {rd, data}
// Revision    : 1.0 - initial release
// ============================================================================
package fp_wb_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic {
    REQ_FPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_rec_t;

endpackage
`default_nettype wire

// File: rtl/fp_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_wb_rr_arbiter
// Description : Two-way round-robin arbiter for the FP register-file write
//               port. A lone requester is granted at once; on a conflict the
//               requester not chosen at the previous conflict wins.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req_fpu, req_ld - requests (the requesters' valids)
//               gnt_fpu, gnt_ld - one-hot grants (both 0 when idle or in reset)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_rr_arbiter
  import fp_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_fpu,
  input  logic req_ld,
  output logic gnt_fpu,
  output logic gnt_ld
);

  req_id_e last_conflict_grant;
  logic    conflict;

  assign conflict = req_fpu & req_ld;

  // Grants are suppressed during reset so a held request is not acknowledged
  // in a cycle whose state is about to be discarded.
  always_comb begin
    gnt_fpu = 1'b0;
    gnt_ld  = 1'b0;
    if (!rst) begin
      if (conflict) begin
        gnt_ld  = (last_conflict_grant == REQ_FPU);
        gnt_fpu = ~gnt_ld;
      end else begin
        gnt_fpu = req_fpu;
        gnt_ld  = req_ld;
      end
    end
  end

  // Only conflicts move the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_conflict_grant <= REQ_FPU;
    end else if (conflict) begin
      last_conflict_grant <= gnt_ld ? REQ_LD : REQ_FPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpr_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fpr_wb_scoreboard
// Description : FP register-file writeback controller. Arbitrates the single
//               RF write port between the FPU and the FLW load path, registers
//               the winning write, and keeps a per-register busy scoreboard
//               that stalls issue on RAW/WAW hazards.
// Ports       : clk, rst                         - clock, sync active-high reset
//               issue_valid/rd/rs1..3/use_rs1..3 - decode issue request
//               issue_stall                      - hazard, decode must hold
//               fpu_valid/rd/data, fpu_ready     - FPU writeback handshake
//               ld_valid/rd/data, ld_ready       - load writeback handshake
//               rf_we, rf_wa, rf_wd              - RF write port
//               busy_vec                         - scoreboard (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module fpr_wb_scoreboard #(
  parameter int NREG = fp_wb_pkg::NREG,
  parameter int AW   = fp_wb_pkg::AW,
  parameter int DW   = fp_wb_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rs3,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_use_rs3,
  output logic            issue_stall,
  input  logic            fpu_valid,
  input  logic [AW-1:0]   fpu_rd,
  input  logic [DW-1:0]   fpu_data,
  output logic            fpu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd,
  output logic [NREG-1:0] busy_vec
);

  import fp_wb_pkg::*;

  logic            gnt_fpu;
  logic            gnt_ld;
  wb_rec_t         wb_next;
  wb_rec_t         wb_q;
  logic            we_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic            src_hz1;
  logic            src_hz2;
  logic            src_hz3;
  logic            issue_fire;

  fp_wb_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_fpu (fpu_valid),
    .req_ld  (ld_valid),
    .gnt_fpu (gnt_fpu),
    .gnt_ld  (gnt_ld)
  );

  assign fpu_ready = gnt_fpu;
  assign ld_ready  = gnt_ld;

  always_comb begin
    wb_next = wb_q;
    if (gnt_fpu) begin
      wb_next.rd   = fpu_rd;
      wb_next.data = fpu_data;
    end else if (gnt_ld) begin
      wb_next.rd   = ld_rd;
      wb_next.data = ld_data;
    end
  end

  // A source being written this cycle is safe: the RF is write-first, so the
  // read sees the value on rf_wd. The destination check has no such exemption
  // because the issuing instruction's result could be overtaken.
  assign src_hz1 = issue_use_rs1 & busy_q[issue_rs1] & ~(we_q & (wb_q.rd == issue_rs1));
  assign src_hz2 = issue_use_rs2 & busy_q[issue_rs2] & ~(we_q & (wb_q.rd == issue_rs2));
  assign src_hz3 = issue_use_rs3 & busy_q[issue_rs3] & ~(we_q & (wb_q.rd == issue_rs3));

  assign issue_stall = issue_valid & (busy_q[issue_rd] | src_hz1 | src_hz2 | src_hz3);
  assign issue_fire  = issue_valid & ~issue_stall;

  // Clear for the write in flight first, then set for the new issue so that a
  // coincident set/clear on the same index leaves the register busy.
  always_comb begin
    busy_next = busy_q;
    if (we_q) begin
      busy_next[wb_q.rd] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      wb_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= gnt_fpu | gnt_ld;
      wb_q   <= wb_next;
      busy_q <= busy_next;
    end
  end

  assign rf_we    = we_q;
  assign rf_wa    = wb_q.rd;
  assign rf_wd    = wb_q.data;
  assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpr_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpr_wb_scoreboard
// Description : Self-checking bench for fpr_wb_scoreboard: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpr_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, issue_rs3;
  logic        issue_use_rs1, issue_use_rs2, issue_use_rs3;
  logic        issue_stall;
  logic        fpu_valid;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        fpu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  fpr_wb_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_use_rs3(issue_use_rs3), .issue_stall(issue_stall),
    .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model state: per-register busy flags, the write in flight, and
  // which requester won the most recent conflict (0 = FPU, 1 = load).
  bit          m_busy [32];
  bit          m_we;
  int          m_wa;
  logic [31:0] m_wd;
  int          m_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_use_rs3 = 1'b0;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic bit model_src_hazard(bit use_r, int r);
    return use_r && m_busy[r] && !(m_we && m_wa == r);
  endfunction

  function automatic bit model_stall();
    if (!issue_valid) return 1'b0;
    return m_busy[int'(issue_rd)]
        || model_src_hazard(issue_use_rs1, int'(issue_rs1))
        || model_src_hazard(issue_use_rs2, int'(issue_rs2))
        || model_src_hazard(issue_use_rs3, int'(issue_rs3));
  endfunction

  // Who wins the port this cycle: -1 none, 0 FPU, 1 load.
  function automatic int model_winner();
    if (rst) return -1;
    if (fpu_valid && ld_valid) return (m_last == 0) ? 1 : 0;
    if (fpu_valid) return 0;
    if (ld_valid) return 1;
    return -1;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int w;
    bit st;
    w  = model_winner();
    st = model_stall();
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_wa = 0; m_wd = '0; m_last = 0;
    end else begin
      if (fpu_valid && ld_valid) m_last = w;
      if (m_we) m_busy[m_wa] = 1'b0;
      if (issue_valid && !st) m_busy[int'(issue_rd)] = 1'b1;
      m_we = (w >= 0);
      if (w == 0) begin m_wa = int'(fpu_rd); m_wd = fpu_data; end
      if (w == 1) begin m_wa = int'(ld_rd);  m_wd = ld_data;  end
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    n_checks++; if (rf_wa !== 5'd0 || rf_wd !== 32'h0) begin n_fail++; $display("FAIL reset_wa_wd got=%0d/%h exp=0/0", rf_wa, rf_wd); end
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd9; issue_use_rs1 = 1'b1;
    #1;
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", issue_stall); end
    idle_inputs();
  endtask

  task automatic test_raw_bypass();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue got=%b exp=0", issue_stall); end
    tick();
    n_checks++; if (busy_vec !== 32'h8) begin n_fail++; $display("FAIL raw_busy_set got=%h exp=%h", busy_vec, 32'h8); end
    issue_rd = 5'd10; issue_rs1 = 5'd3; issue_use_rs1 = 1'b1;
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F800000;
    #1;
    n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall got=%b exp=1", issue_stall); end
    n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL raw_fpu_ready got=%b exp=1", fpu_ready); end
    tick();
    fpu_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h3F800000)
      begin n_fail++; $display("FAIL raw_write got=%b/%0d/%h exp=1/3/3f800000", rf_we, rf_wa, rf_wd); end
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_bypass got=%b exp=0", issue_stall); end
    issue_valid = 1'b0;
    tick();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clear got=%h exp=0", busy_vec); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int fi, li;
    bit exp_ld;
    do_reset();
    fi = 0; li = 0;
    for (int i = 0; i < 4; i++) begin
      fpu_valid = 1'b1; fpu_rd = 5'(10 + fi); fpu_data = 32'hF000_0000 + 32'(fi);
      ld_valid  = 1'b1; ld_rd  = 5'(1 + li);  ld_data  = 32'hA000_0000 + 32'(li);
      exp_ld = (i % 2 == 0);
      #1;
      n_checks++; if (ld_ready !== exp_ld || fpu_ready !== !exp_ld)
        begin n_fail++; $display("FAIL b2b_grant[%0d] got=fpu%b/ld%b exp_ld=%b", i, fpu_ready, ld_ready, exp_ld); end
      tick();
      n_checks++; if (rf_we !== 1'b1 || rf_wa !== (exp_ld ? 5'(1 + li) : 5'(10 + fi)))
        begin n_fail++; $display("FAIL b2b_write[%0d] got=%b/%0d exp=1/%0d", i, rf_we, rf_wa, exp_ld ? 1 + li : 10 + fi); end
      if (exp_ld) li++; else fi++;
    end
    idle_inputs();
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_waw();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    #1;
    n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", issue_stall); end
    fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h4040_0000;
    tick();
    fpu_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5) begin n_fail++; $display("FAIL waw_write got=%b/%0d exp=1/5", rf_we, rf_wa); end
    n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_no_bypass got=%b exp=1", issue_stall); end
    tick();
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL waw_release got=%b exp=0", issue_stall); end
    idle_inputs();
    tick();
  endtask

  task automatic test_src_mask();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd8; issue_rs3 = 5'd7; issue_use_rs3 = 1'b0;
    #1;
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL mask_rs3_off got=%b exp=0", issue_stall); end
    issue_use_rs3 = 1'b1;
    #1;
    n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL mask_rs3_on got=%b exp=1", issue_stall); end
    issue_use_rs3 = 1'b0; issue_rs2 = 5'd7; issue_use_rs2 = 1'b1;
    #1;
    n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL mask_rs2_on got=%b exp=1", issue_stall); end
    issue_valid = 1'b0;
    #1;
    n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL mask_no_valid got=%b exp=0", issue_stall); end
    tick();
    n_checks++; if (busy_vec !== 32'h80) begin n_fail++; $display("FAIL mask_busy got=%h exp=%h", busy_vec, 32'h80); end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    issue_valid = 1'b0;
    n_checks++; if (busy_vec !== 32'h0000FFFF) begin n_fail++; $display("FAIL midrst_fill got=%h exp=0000ffff", busy_vec); end
    fpu_valid = 1'b1; fpu_rd = 5'd2; fpu_data = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", fpu_ready); end
    tick();
    rst = 1'b0;
    n_checks++; if (rf_we !== 1'b0 || busy_vec !== 32'h0)
      begin n_fail++; $display("FAIL midrst_after got=%b/%h exp=0/0", rf_we, busy_vec); end
    #1;
    n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_regrant got=%b exp=1", fpu_ready); end
    tick();
    fpu_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL midrst_write got=%b/%0d/%h exp=1/2/deadbeef", rf_we, rf_wa, rf_wd); end
    idle_inputs();
  endtask

  task automatic test_f0();
    do_reset();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h12345678;
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL f0_ready got=%b exp=1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd0 || rf_wd !== 32'h12345678)
      begin n_fail++; $display("FAIL f0_write got=%b/%0d/%h exp=1/0/12345678", rf_we, rf_wa, rf_wd); end
    tick();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL f0_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_random();
    bit exp_stall, exp_fr, exp_lr;
    int w;
    logic [31:0] exp_busy;
    idle_inputs();
    rst = 1'b1;
    model_edge();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_rd      = 5'($urandom_range(0, 31));
      issue_rs1     = 5'($urandom_range(0, 31));
      issue_rs2     = 5'($urandom_range(0, 31));
      issue_rs3     = 5'($urandom_range(0, 31));
      issue_use_rs1 = 1'($urandom);
      issue_use_rs2 = 1'($urandom);
      issue_use_rs3 = 1'($urandom);
      // Requesters hold their payload until accepted.
      if (!fpu_valid && $urandom_range(0, 1) == 1) begin
        fpu_valid = 1'b1; fpu_rd = 5'($urandom_range(0, 31)); fpu_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 1) == 1) begin
        ld_valid = 1'b1; ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
      end
      #1;
      exp_stall = model_stall();
      w = model_winner();
      exp_fr = (w == 0);
      exp_lr = (w == 1);
      n_checks++; if (issue_stall !== exp_stall)
        begin n_fail++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, issue_stall, exp_stall); end
      n_checks++; if (fpu_ready !== exp_fr || ld_ready !== exp_lr)
        begin n_fail++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, fpu_ready, ld_ready, exp_fr, exp_lr); end
      model_edge();
      tick();
      if (exp_fr) fpu_valid = 1'b0;
      if (exp_lr) ld_valid = 1'b0;
      exp_busy = model_busy_vec();
      n_checks++; if (busy_vec !== exp_busy)
        begin n_fail++; $display("FAIL rand_busy c=%0d got=%h exp=%h", c, busy_vec, exp_busy); end
      n_checks++; if (rf_we !== m_we || (m_we && (int'(rf_wa) != m_wa || rf_wd !== m_wd)))
        begin n_fail++; $display("FAIL rand_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_raw_bypass();
    test_back_to_back();
    test_waw();
    test_src_mask();
    test_reset_midop();
    test_f0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
